// File: rtl/wsram_arb_pkg.sv
// rtl/wsram_arb_pkg.sv - shared types and constants for the weight SRAM port arbiter
// Purpose: owner tag encoding for the read return path, SRAM read latency, and
//          the width helper for the starvation counter.
// Ports:   none (package)
package wsram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DMA  = 2'd1,
    OWN_R0   = 2'd2,
    OWN_R1   = 2'd3
  } owner_e;

  localparam int RAM_RD_LAT = 1;

  // STARVE_W = $clog2(STARVE_MAX+1); a function because STARVE_MAX is a module parameter
  function automatic int starve_w(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/wsram_rr_pick.sv
// rtl/wsram_rr_pick.sv - 2-way round-robin picker for the two SRAM readers
// Purpose: choose one of two requesters; the pointer only matters when both request.
// Ports:   req_i     [1:0] request vector {r1, r0}
//          ptr_i           current pointer (0 = r0 preferred, 1 = r1 preferred)
//          pick_o    [1:0] one-hot pick {r1, r0}, zero when nobody requests
//          ptr_nxt_o       pointer after the pick (moves to the other reader)
module wsram_rr_pick (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] pick_o,
  output logic       ptr_nxt_o
);

  always_comb begin
    pick_o = 2'b00;
    case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11:   pick_o = ptr_i ? 2'b10 : 2'b01;
      default: pick_o = 2'b00;
    endcase
  end

  assign ptr_nxt_o = pick_o[0] ? 1'b1 : (pick_o[1] ? 1'b0 : ptr_i);

endmodule

// File: rtl/wsram_port_arbiter.sv
// rtl/wsram_port_arbiter.sv - req/gnt arbiter sharing one single-port weight SRAM
// Purpose: DMA write path has priority; readers r0/r1 share round-robin; a starvation
//          counter forces a reader grant after STARVE_MAX consecutive DMA wins.
// Ports:   i_clk/i_rst_n            clock, async active-low reset
//          i_dma_*/o_dma_gnt        write requester
//          i_rX_req/addr, o_rX_gnt  read requesters (X = 0, 1)
//          o_rX_rvalid/o_rX_rdata   read return, one cycle after grant
//          o_ram_*/i_ram_rdata      SRAM interface (1-cycle read latency)
//          o_addr_err, o_busy       status
// Option:  WSRAM_ARB_PERF_EN adds i_perf_clr and o_perf_{wr,rd,stall}_cnt.
module wsram_port_arbiter
  import wsram_arb_pkg::*;
#(
  parameter int DW         = 16,
  parameter int AW         = 16,
  parameter int RAM_AW     = 11,
  parameter int STARVE_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dma_req,
  input  logic [AW-1:0]     i_dma_addr,
  input  logic [DW-1:0]     i_dma_wdata,
  output logic              o_dma_gnt,
  input  logic              i_r0_req,
  input  logic [AW-1:0]     i_r0_addr,
  output logic              o_r0_gnt,
  output logic              o_r0_rvalid,
  output logic [DW-1:0]     o_r0_rdata,
  input  logic              i_r1_req,
  input  logic [AW-1:0]     i_r1_addr,
  output logic              o_r1_gnt,
  output logic              o_r1_rvalid,
  output logic [DW-1:0]     o_r1_rdata,
  output logic              o_ram_cs,
  output logic              o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [DW-1:0]     o_ram_wdata,
  input  logic [DW-1:0]     i_ram_rdata,
  output logic              o_addr_err,
  output logic              o_busy
`ifdef WSRAM_ARB_PERF_EN
  ,
  input  logic              i_perf_clr,
  output logic [31:0]       o_perf_wr_cnt,
  output logic [31:0]       o_perf_rd_cnt,
  output logic [31:0]       o_perf_stall_cnt
`endif
);

  localparam int STARVE_W = starve_w(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic                rr_ptr_q, rr_ptr_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  owner_e              owner_q, owner_d;
  logic                oor_q;
  logic [RAM_AW-1:0]   addr_hold_q;
  logic [DW-1:0]       wdata_hold_q;
  logic [DW-1:0]       r0_hold_q, r1_hold_q;

  logic        reader_any, starve_hit, dma_win;
  logic [1:0]  pick;
  logic        ptr_nxt;
  logic        rd_gnt, any_gnt, in_range;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] rd_word;

  assign reader_any = i_r0_req | i_r1_req;
  assign starve_hit = (starve_cnt_q == STARVE_LIM) && reader_any;
  // Grants are held off while reset is asserted so every output reads 0 in reset
  assign dma_win    = i_rst_n & i_dma_req & ~starve_hit;

  wsram_rr_pick u_rr_pick (
    .req_i    ({i_r1_req, i_r0_req} & {2{i_rst_n}}),
    .ptr_i    (rr_ptr_q),
    .pick_o   (pick),
    .ptr_nxt_o(ptr_nxt)
  );

  assign o_dma_gnt = dma_win;
  assign o_r0_gnt  = pick[0] & ~dma_win;
  assign o_r1_gnt  = pick[1] & ~dma_win;
  assign rd_gnt    = o_r0_gnt | o_r1_gnt;
  assign any_gnt   = o_dma_gnt | rd_gnt;

  assign sel_addr = o_dma_gnt ? i_dma_addr : (o_r0_gnt ? i_r0_addr : i_r1_addr);
  assign in_range = (sel_addr[AW-1:RAM_AW] == '0);

  // Out-of-range grants complete without touching the SRAM so the requester never stalls
  assign o_ram_cs    = any_gnt & in_range;
  assign o_ram_we    = o_dma_gnt & in_range;
  assign o_addr_err  = any_gnt & ~in_range;
  assign o_ram_addr  = any_gnt ? sel_addr[RAM_AW-1:0] : addr_hold_q;
  assign o_ram_wdata = o_dma_gnt ? i_dma_wdata : wdata_hold_q;

  assign rd_word     = oor_q ? '0 : i_ram_rdata;
  assign o_r0_rvalid = (owner_q == OWN_R0);
  assign o_r1_rvalid = (owner_q == OWN_R1);
  assign o_r0_rdata  = o_r0_rvalid ? rd_word : r0_hold_q;
  assign o_r1_rdata  = o_r1_rvalid ? rd_word : r1_hold_q;

  assign o_busy = i_rst_n & (i_dma_req | reader_any | (owner_q != OWN_NONE));

  always_comb begin
    rr_ptr_d     = rd_gnt ? ptr_nxt : rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (!reader_any || rd_gnt) begin
      starve_cnt_d = '0;
    end else if (o_dma_gnt && starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    owner_d = o_r0_gnt ? OWN_R0 : (o_r1_gnt ? OWN_R1 : OWN_NONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q     <= 1'b0;
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
      oor_q        <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      r0_hold_q    <= '0;
      r1_hold_q    <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      oor_q        <= ~in_range;
      if (any_gnt)     addr_hold_q  <= o_ram_addr;
      if (o_dma_gnt)   wdata_hold_q <= i_dma_wdata;
      if (o_r0_rvalid) r0_hold_q    <= rd_word;
      if (o_r1_rvalid) r1_hold_q    <= rd_word;
    end
  end

`ifdef WSRAM_ARB_PERF_EN
  logic [31:0] perf_wr_q, perf_rd_q, perf_stall_q;
  logic        stall;

  assign stall = i_rst_n & (i_dma_req | reader_any) & ~any_gnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_wr_q    <= '0;
      perf_rd_q    <= '0;
      perf_stall_q <= '0;
    end else if (i_perf_clr) begin
      perf_wr_q    <= '0;
      perf_rd_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (o_dma_gnt && perf_wr_q != '1)    perf_wr_q    <= perf_wr_q + 32'd1;
      if (rd_gnt && perf_rd_q != '1)       perf_rd_q    <= perf_rd_q + 32'd1;
      if (stall && perf_stall_q != '1)     perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign o_perf_wr_cnt    = perf_wr_q;
  assign o_perf_rd_cnt    = perf_rd_q;
  assign o_perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_wsram_port_arbiter.sv
// tb/tb_wsram_port_arbiter.sv - directed table-driven bench for wsram_port_arbiter
module tb_wsram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dma_req = 1'b0, r0_req = 1'b0, r1_req = 1'b0;
  logic [15:0] dma_addr = '0, dma_wdata = '0, r0_addr = '0, r1_addr = '0;
  logic        dma_gnt, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [15:0] r0_rdata, r1_rdata;
  logic        ram_cs, ram_we, addr_err, busy;
  logic [10:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;
`ifdef WSRAM_ARB_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_wr, perf_rd, perf_stall;
`endif

  logic [15:0] mem [0:2047];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  wsram_port_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_dma_req(dma_req), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata), .o_dma_gnt(dma_gnt),
    .i_r0_req(r0_req), .i_r0_addr(r0_addr), .o_r0_gnt(r0_gnt),
    .o_r0_rvalid(r0_rvalid), .o_r0_rdata(r0_rdata),
    .i_r1_req(r1_req), .i_r1_addr(r1_addr), .o_r1_gnt(r1_gnt),
    .o_r1_rvalid(r1_rvalid), .o_r1_rdata(r1_rdata),
    .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata), .o_addr_err(addr_err), .o_busy(busy)
`ifdef WSRAM_ARB_PERF_EN
    , .i_perf_clr(perf_clr), .o_perf_wr_cnt(perf_wr), .o_perf_rd_cnt(perf_rd),
    .o_perf_stall_cnt(perf_stall)
`endif
  );

  typedef struct {
    logic        dr;
    logic [15:0] da;
    logic [15:0] dw;
    logic        q0;
    logic [15:0] a0;
    logic        q1;
    logic [15:0] a1;
    logic [2:0]  gnt;   // {r1, r0, dma}
    logic        cs;
    logic        we;
    logic        err;
    logic        v0;
    logic [15:0] d0;
    logic        v1;
    logic [15:0] d1;
  } vec_t;

  vec_t tv [0:17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic dr, input logic [15:0] da, input logic [15:0] dw,
                       input logic q0, input logic [15:0] a0,
                       input logic q1, input logic [15:0] a1);
    dma_req = dr; dma_addr = da; dma_wdata = dw;
    r0_req = q0; r0_addr = a0; r1_req = q1; r1_addr = a1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;

    //            dr da      dw       q0 a0      q1 a1      gnt    cs we er v0 d0       v1 d1
    tv[0]  = '{1, 16'h010, 16'hA5A5, 0, 16'h000, 0, 16'h000, 3'b001, 1, 1, 0, 0, 16'h0000, 0, 16'h0000};
    tv[1]  = '{1, 16'h001, 16'h1111, 0, 16'h000, 0, 16'h000, 3'b001, 1, 1, 0, 0, 16'h0000, 0, 16'h0000};
    tv[2]  = '{1, 16'h002, 16'h2222, 0, 16'h000, 0, 16'h000, 3'b001, 1, 1, 0, 0, 16'h0000, 0, 16'h0000};
    tv[3]  = '{0, 16'h000, 16'h0000, 1, 16'h001, 1, 16'h002, 3'b010, 1, 0, 0, 0, 16'h0000, 0, 16'h0000};
    tv[4]  = '{0, 16'h000, 16'h0000, 1, 16'h001, 1, 16'h002, 3'b100, 1, 0, 0, 1, 16'h1111, 0, 16'h0000};
    tv[5]  = '{0, 16'h000, 16'h0000, 1, 16'h001, 1, 16'h002, 3'b010, 1, 0, 0, 0, 16'h1111, 1, 16'h2222};
    tv[6]  = '{0, 16'h000, 16'h0000, 1, 16'h001, 1, 16'h002, 3'b100, 1, 0, 0, 1, 16'h1111, 0, 16'h2222};
    tv[7]  = '{0, 16'h000, 16'h0000, 0, 16'h000, 0, 16'h000, 3'b000, 0, 0, 0, 0, 16'h1111, 1, 16'h2222};
    tv[8]  = '{0, 16'h000, 16'h0000, 1, 16'h010, 0, 16'h000, 3'b010, 1, 0, 0, 0, 16'h1111, 0, 16'h2222};
    tv[9]  = '{0, 16'h000, 16'h0000, 0, 16'h000, 0, 16'h000, 3'b000, 0, 0, 0, 1, 16'hA5A5, 0, 16'h2222};
    tv[10] = '{1, 16'h030, 16'h0BAD, 1, 16'h010, 0, 16'h000, 3'b001, 1, 1, 0, 0, 16'hA5A5, 0, 16'h2222};
    tv[11] = '{0, 16'h000, 16'h0000, 1, 16'h800, 0, 16'h000, 3'b010, 0, 0, 1, 0, 16'hA5A5, 0, 16'h2222};
    tv[12] = '{0, 16'h000, 16'h0000, 0, 16'h000, 0, 16'h000, 3'b000, 0, 0, 0, 1, 16'h0000, 0, 16'h2222};
    tv[13] = '{1, 16'hFFFF, 16'hBEEF, 0, 16'h000, 0, 16'h000, 3'b001, 0, 0, 1, 0, 16'h0000, 0, 16'h2222};
    tv[14] = '{0, 16'h000, 16'h0000, 0, 16'h000, 1, 16'h7FF, 3'b100, 1, 0, 0, 0, 16'h0000, 0, 16'h2222};
    tv[15] = '{0, 16'h000, 16'h0000, 0, 16'h000, 0, 16'h000, 3'b000, 0, 0, 0, 0, 16'h0000, 1, 16'h0000};
    tv[16] = '{0, 16'h000, 16'h0000, 0, 16'h000, 1, 16'h030, 3'b100, 1, 0, 0, 0, 16'h0000, 0, 16'h0000};
    tv[17] = '{0, 16'h000, 16'h0000, 0, 16'h000, 0, 16'h000, 3'b000, 0, 0, 0, 0, 16'h0000, 1, 16'h0BAD};

    // Reset with every request asserted: nothing may be granted
    drive(1, 16'h010, 16'h1234, 1, 16'h001, 1, 16'h002);
    #1;
    chk("rst_gnt", {r1_gnt, r0_gnt, dma_gnt}, 3'b000);
    chk("rst_cs_we_err", {ram_cs, ram_we, addr_err}, 3'b000);
    chk("rst_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", {r1_rdata, r0_rdata}, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tv[i].dr, tv[i].da, tv[i].dw, tv[i].q0, tv[i].a0, tv[i].q1, tv[i].a1);
      #1;
      chk($sformatf("v%0d_gnt", i), {r1_gnt, r0_gnt, dma_gnt}, tv[i].gnt);
      chk($sformatf("v%0d_cs", i), ram_cs, tv[i].cs);
      chk($sformatf("v%0d_we", i), ram_we, tv[i].we);
      chk($sformatf("v%0d_err", i), addr_err, tv[i].err);
      chk($sformatf("v%0d_r0v", i), r0_rvalid, tv[i].v0);
      chk($sformatf("v%0d_r0d", i), r0_rdata, tv[i].d0);
      chk($sformatf("v%0d_r1v", i), r1_rvalid, tv[i].v1);
      chk($sformatf("v%0d_r1d", i), r1_rdata, tv[i].d1);
    end
    chk("oor_write_dropped", mem[11'h7FF], 16'h0000);

    // Starvation: DMA and r1 both hold requests; r1 wins after 8 DMA grants
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(1, 16'h040 + 16'(c), 16'(c), 0, 0, 1, 16'h001);
      #1;
      chk($sformatf("starve_c%0d_gnt", c), {r1_gnt, r0_gnt, dma_gnt},
          (c == 8 || c == 17) ? 3'b100 : 3'b001);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset while an r1 read is in flight drops its rvalid
    @(negedge clk);
    drive(1, 16'h020, 16'h5A5A, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 16'h020);
    #1;
    chk("midrst_gnt", {r1_gnt, r0_gnt, dma_gnt}, 3'b100);
    #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_r1v", r1_rvalid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 16'h020);
    #1;
    chk("reissue_gnt", {r1_gnt, r0_gnt, dma_gnt}, 3'b100);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reissue_r1v", r1_rvalid, 1'b1);
    chk("reissue_r1d", r1_rdata, 16'h5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
